// File: rtl/servant_spi_arbiter.sv
// rtl/servant_spi_arbiter.sv - round-robin arbiter sharing one SPI memory port between instruction and data buses
module servant_spi_arbiter #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int TIMEOUT       = 4095,
    parameter bit INIT_WREN     = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic [ADDRESS_WIDTH-3:0] i_ibus_adr,
    input  logic                     i_ibus_cyc,
    output logic [31:0]              o_ibus_rdt,
    output logic                     o_ibus_ack,

    input  logic [ADDRESS_WIDTH-3:0] i_dbus_adr,
    input  logic [31:0]              i_dbus_dat,
    input  logic [3:0]               i_dbus_sel,
    input  logic                     i_dbus_we,
    input  logic                     i_dbus_cyc,
    output logic [31:0]              o_dbus_rdt,
    output logic                     o_dbus_ack,

    output logic [ADDRESS_WIDTH-3:0] o_spi_adr,
    output logic [31:0]              o_spi_dat,
    output logic [3:0]               o_spi_sel,
    output logic                     o_spi_we,
    output logic                     o_spi_cyc,
    input  logic [31:0]              i_spi_rdt,
    input  logic                     i_spi_ack,

    output logic                     o_init_done,
    output logic                     o_timeout
);

    localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit WD_EN = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_INIT,
        S_INIT_WAIT,
        S_IDLE,
        S_GRANT_I,
        S_GRANT_D,
        S_RELEASE
    } state_t;

    // Without the write-enable preamble the arbiter starts serving immediately.
    localparam state_t RESET_STATE = INIT_WREN ? S_INIT : S_IDLE;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-3:0] spi_adr_q;
    logic [31:0]              spi_dat_q;
    logic [3:0]               spi_sel_q;
    logic                     spi_we_q;
    logic                     spi_cyc_q;
    logic [31:0]              ibus_rdt_q;
    logic                     ibus_ack_q;
    logic [31:0]              dbus_rdt_q;
    logic                     dbus_ack_q;
    logic                     init_done_q;
    logic                     timeout_q;
    logic [WDW-1:0]           wdog_q;
    logic                     last_d_q;     // 0 = ibus granted last, 1 = dbus granted last

    logic req_i;
    logic req_d;
    logic grant_d_d;
    logic wd_expired;

    // Requester masking and round-robin pick; a requester being acked this cycle is not a new request.
    always_comb begin
        req_i     = i_ibus_cyc & ~ibus_ack_q;
        req_d     = i_dbus_cyc & ~dbus_ack_q;
        grant_d_d = req_d & (~req_i | ~last_d_q);
    end

    assign wd_expired = WD_EN && (wdog_q == WD_LAST);

    // Arbitration FSM with registered downstream request, responses and status flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            spi_adr_q   <= '0;
            spi_dat_q   <= '0;
            spi_sel_q   <= '0;
            spi_we_q    <= 1'b0;
            spi_cyc_q   <= 1'b0;
            ibus_rdt_q  <= '0;
            ibus_ack_q  <= 1'b0;
            dbus_rdt_q  <= '0;
            dbus_ack_q  <= 1'b0;
            init_done_q <= 1'b0;
            timeout_q   <= 1'b0;
            wdog_q      <= '0;
            last_d_q    <= 1'b0;
        end else begin
            ibus_ack_q <= 1'b0;
            dbus_ack_q <= 1'b0;
            case (state_q)
                S_INIT: begin
                    spi_cyc_q <= 1'b1;
                    spi_we_q  <= 1'b1;
                    spi_sel_q <= 4'h0;
                    spi_adr_q <= '0;
                    spi_dat_q <= '0;
                    wdog_q    <= '0;
                    state_q   <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (i_spi_ack) begin
                        spi_cyc_q   <= 1'b0;
                        init_done_q <= 1'b1;
                        state_q     <= S_RELEASE;
                    end else if (wd_expired) begin
                        spi_cyc_q   <= 1'b0;
                        init_done_q <= 1'b1;
                        timeout_q   <= 1'b1;
                        state_q     <= S_RELEASE;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    init_done_q <= 1'b1;
                    if (req_i || req_d) begin
                        wdog_q    <= '0;
                        spi_cyc_q <= 1'b1;
                        if (grant_d_d) begin
                            spi_adr_q <= i_dbus_adr;
                            spi_dat_q <= i_dbus_dat;
                            spi_sel_q <= i_dbus_sel;
                            spi_we_q  <= i_dbus_we;
                            last_d_q  <= 1'b1;
                            state_q   <= S_GRANT_D;
                        end else begin
                            spi_adr_q <= i_ibus_adr;
                            spi_dat_q <= '0;
                            spi_sel_q <= 4'hF;
                            spi_we_q  <= 1'b0;
                            last_d_q  <= 1'b0;
                            state_q   <= S_GRANT_I;
                        end
                    end
                end
                S_GRANT_I, S_GRANT_D: begin
                    if (i_spi_ack || wd_expired) begin
                        spi_cyc_q <= 1'b0;
                        state_q   <= S_RELEASE;
                        if (!i_spi_ack) begin
                            timeout_q <= 1'b1;
                        end
                        if (state_q == S_GRANT_D) begin
                            dbus_rdt_q <= i_spi_ack ? i_spi_rdt : 32'hFFFF_FFFF;
                            dbus_ack_q <= 1'b1;
                        end else begin
                            ibus_rdt_q <= i_spi_ack ? i_spi_rdt : 32'hFFFF_FFFF;
                            ibus_ack_q <= 1'b1;
                        end
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_spi_adr   = spi_adr_q;
    assign o_spi_dat   = spi_dat_q;
    assign o_spi_sel   = spi_sel_q;
    assign o_spi_we    = spi_we_q;
    assign o_spi_cyc   = spi_cyc_q;
    assign o_ibus_rdt  = ibus_rdt_q;
    assign o_ibus_ack  = ibus_ack_q;
    assign o_dbus_rdt  = dbus_rdt_q;
    assign o_dbus_ack  = dbus_ack_q;
    assign o_init_done = init_done_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_servant_spi_arbiter.sv
// tb/tb_servant_spi_arbiter.sv - scoreboard bench for servant_spi_arbiter
module tb_servant_spi_arbiter;

    logic        clock;
    logic        reset;
    logic [21:0] i_ibus_adr;
    logic        i_ibus_cyc;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [21:0] i_dbus_adr;
    logic [31:0] i_dbus_dat;
    logic [3:0]  i_dbus_sel;
    logic        i_dbus_we;
    logic        i_dbus_cyc;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [21:0] o_spi_adr;
    logic [31:0] o_spi_dat;
    logic [3:0]  o_spi_sel;
    logic        o_spi_we;
    logic        o_spi_cyc;
    logic [31:0] i_spi_rdt;
    logic        i_spi_ack;
    logic        o_init_done;
    logic        o_timeout;

    servant_spi_arbiter #(
        .ADDRESS_WIDTH(24),
        .TIMEOUT(15),
        .INIT_WREN(1'b1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .i_ibus_adr(i_ibus_adr),
        .i_ibus_cyc(i_ibus_cyc),
        .o_ibus_rdt(o_ibus_rdt),
        .o_ibus_ack(o_ibus_ack),
        .i_dbus_adr(i_dbus_adr),
        .i_dbus_dat(i_dbus_dat),
        .i_dbus_sel(i_dbus_sel),
        .i_dbus_we(i_dbus_we),
        .i_dbus_cyc(i_dbus_cyc),
        .o_dbus_rdt(o_dbus_rdt),
        .o_dbus_ack(o_dbus_ack),
        .o_spi_adr(o_spi_adr),
        .o_spi_dat(o_spi_dat),
        .o_spi_sel(o_spi_sel),
        .o_spi_we(o_spi_we),
        .o_spi_cyc(o_spi_cyc),
        .i_spi_rdt(i_spi_rdt),
        .i_spi_ack(i_spi_ack),
        .o_init_done(o_init_done),
        .o_timeout(o_timeout)
    );

    typedef struct packed {
        logic [21:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } spi_t;

    typedef struct packed {
        logic        is_d;
        logic [31:0] rdt;
    } rsp_t;

    spi_t        exp_spi[$];
    rsp_t        exp_rsp[$];
    logic [31:0] rdt_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int hi_cnt = 0;
    int hi_len = 0;
    int unsigned rsp_lat = 0;
    bit rsp_en = 1'b1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_spi(input logic [21:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic we);
        spi_t s;
        s.adr = adr; s.dat = dat; s.sel = sel; s.we = we;
        exp_spi.push_back(s);
    endtask

    task automatic push_rsp(input logic is_d, input logic [31:0] rdt);
        rsp_t r;
        r.is_d = is_d; r.rdt = rdt;
        exp_rsp.push_back(r);
    endtask

    // Downstream SPI model: acks rsp_lat cycles into a request, returning queued read data.
    initial begin : responder
        int cnt;
        cnt = 0;
        i_spi_ack = 1'b0;
        i_spi_rdt = '0;
        forever begin
            @(negedge clock);
            if (o_spi_cyc && !i_spi_ack) begin
                cnt++;
                if (rsp_en && cnt > int'(rsp_lat)) begin
                    i_spi_ack = 1'b1;
                    i_spi_rdt = 32'h0;
                    if (rdt_q.size() > 0) i_spi_rdt = rdt_q.pop_front();
                end
            end else begin
                i_spi_ack = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: checks each downstream request and each requester ack against the scoreboard.
    initial begin : monitor
        spi_t cur, cap, e;
        rsp_t r;
        logic cyc_prev, ack_prev;
        logic [31:0] got_rdt;
        cyc_prev = 1'b0;
        ack_prev = 1'b0;
        cap = '0;
        forever begin
            @(negedge clock);
            cur = {o_spi_adr, o_spi_dat, o_spi_sel, o_spi_we};
            if (o_spi_cyc) begin
                if (!cyc_prev) begin
                    hi_cnt = 1;
                    cap = cur;
                    if (exp_spi.size() == 0) begin
                        chk("spi_unexpected_req", 64'(cur), 64'(0));
                    end else begin
                        e = exp_spi.pop_front();
                        chk("spi_req", 64'(cur), 64'(e));
                    end
                end else begin
                    hi_cnt++;
                    chk("spi_stable", 64'(cur), 64'(cap));
                end
            end else if (cyc_prev) begin
                hi_len = hi_cnt;
            end
            cyc_prev = o_spi_cyc;

            if (o_ibus_ack || o_dbus_ack) begin
                chk("ack_single_cycle", 64'(ack_prev), 64'(0));
                chk("ack_both_ports", 64'(o_ibus_ack & o_dbus_ack), 64'(0));
                if (exp_rsp.size() == 0) begin
                    chk("ack_unexpected", 64'({o_ibus_ack, o_dbus_ack}), 64'(0));
                end else begin
                    r = exp_rsp.pop_front();
                    got_rdt = o_dbus_ack ? o_dbus_rdt : o_ibus_rdt;
                    chk("ack_port_is_dbus", 64'(o_dbus_ack), 64'(r.is_d));
                    chk("ack_rdt", 64'(got_rdt), 64'(r.rdt));
                end
            end
            ack_prev = o_ibus_ack | o_dbus_ack;
        end
    end

    task automatic ibus_req(input logic [21:0] adr);
        int t;
        i_ibus_adr = adr;
        i_ibus_cyc = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clock);
            if (o_ibus_ack) break;
        end
        if (t == 200) chk("ibus_ack_wait", 64'(0), 64'(1));
        i_ibus_cyc = 1'b0;
    endtask

    // mode 0: hold inputs; 1: scramble inputs once granted; 2: drop cyc once granted.
    task automatic dbus_req(input logic [21:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                            input logic we, input int mode);
        int t;
        bit touched;
        touched = 1'b0;
        i_dbus_adr = adr;
        i_dbus_dat = dat;
        i_dbus_sel = sel;
        i_dbus_we  = we;
        i_dbus_cyc = 1'b1;
        for (t = 0; t < 200; t++) begin
            @(negedge clock);
            if (o_dbus_ack) break;
            if (o_spi_cyc && !touched && mode == 1) begin
                i_dbus_adr = ~adr; i_dbus_dat = ~dat; i_dbus_sel = ~sel; i_dbus_we = ~we;
                touched = 1'b1;
            end
            if (o_spi_cyc && !touched && mode == 2) begin
                i_dbus_cyc = 1'b0;
                touched = 1'b1;
            end
        end
        if (t == 200) chk("dbus_ack_wait", 64'(0), 64'(1));
        i_dbus_cyc = 1'b0;
    endtask

    task automatic wait_init_done();
        int t;
        for (t = 0; t < 100; t++) begin
            @(negedge clock);
            if (o_init_done) break;
        end
        chk("init_done", 64'(o_init_done), 64'(1));
    endtask

    initial begin : stimulus
        int t;
        reset = 1'b1;
        i_ibus_adr = '0; i_ibus_cyc = 1'b0;
        i_dbus_adr = '0; i_dbus_dat = '0; i_dbus_sel = '0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        chk("rst_spi_cyc", 64'(o_spi_cyc), 64'(0));
        chk("rst_spi_fields", 64'({o_spi_adr, o_spi_dat, o_spi_sel, o_spi_we}), 64'(0));
        chk("rst_acks", 64'({o_ibus_ack, o_dbus_ack}), 64'(0));
        chk("rst_rdts", 64'({o_ibus_rdt, o_dbus_rdt}), 64'(0));
        chk("rst_init_done", 64'(o_init_done), 64'(0));
        chk("rst_timeout", 64'(o_timeout), 64'(0));

        // Init write-enable transfer, acked in its fifth cycle, no requester ack
        push_spi(22'h0, 32'h0, 4'h0, 1'b1);
        rdt_q.push_back(32'h0BAD_0000);
        rsp_lat = 4;
        reset = 1'b0;
        wait_init_done();
        repeat (3) @(negedge clock);
        chk("init_cyc_len", 64'(hi_len), 64'(5));
        chk("init_timeout", 64'(o_timeout), 64'(0));

        // Data write with inputs scrambled mid-grant
        push_spi(22'h10, 32'hDEAD_BEEF, 4'h3, 1'b1);
        push_rsp(1'b1, 32'h0000_0001);
        rdt_q.push_back(32'h0000_0001);
        dbus_req(22'h10, 32'hDEAD_BEEF, 4'h3, 1'b1, 1);

        // Back-to-back instruction reads, zero downstream latency
        rsp_lat = 0;
        push_spi(22'h20, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b0, 32'h1234_5678);
        rdt_q.push_back(32'h1234_5678);
        push_spi(22'h21, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b0, 32'hCAFE_F00D);
        rdt_q.push_back(32'hCAFE_F00D);
        ibus_req(22'h20);
        ibus_req(22'h21);

        // First tie after ibus grant: dbus wins, then ibus
        rsp_lat = 1;
        push_spi(22'h40, 32'h1111_2222, 4'hF, 1'b0);
        push_rsp(1'b1, 32'hAAAA_0001);
        rdt_q.push_back(32'hAAAA_0001);
        push_spi(22'h30, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b0, 32'hBBBB_0002);
        rdt_q.push_back(32'hBBBB_0002);
        fork
            ibus_req(22'h30);
            dbus_req(22'h40, 32'h1111_2222, 4'hF, 1'b0, 0);
        join

        // Lone dbus write, then a tie after a dbus grant: ibus wins
        push_spi(22'h50, 32'h0000_0005, 4'h1, 1'b1);
        push_rsp(1'b1, 32'h0000_0050);
        rdt_q.push_back(32'h0000_0050);
        dbus_req(22'h50, 32'h0000_0005, 4'h1, 1'b1, 0);
        push_spi(22'h31, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b0, 32'hCCCC_0003);
        rdt_q.push_back(32'hCCCC_0003);
        push_spi(22'h41, 32'h3333_4444, 4'h6, 1'b1);
        push_rsp(1'b1, 32'hDDDD_0004);
        rdt_q.push_back(32'hDDDD_0004);
        fork
            ibus_req(22'h31);
            dbus_req(22'h41, 32'h3333_4444, 4'h6, 1'b1, 0);
        join

        // Requester drops cyc mid-grant: transfer still completes and acks once
        rsp_lat = 3;
        push_spi(22'h55, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b1, 32'h5555_AAAA);
        rdt_q.push_back(32'h5555_AAAA);
        dbus_req(22'h55, 32'h0, 4'hF, 1'b0, 2);
        repeat (6) @(negedge clock);
        chk("timeout_before_wd", 64'(o_timeout), 64'(0));

        // Watchdog expiry after 15 cycles with no downstream ack
        rsp_en = 1'b0;
        push_spi(22'h60, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b1, 32'hFFFF_FFFF);
        dbus_req(22'h60, 32'h0, 4'hF, 1'b0, 0);
        @(negedge clock);
        chk("wd_cyc_len", 64'(hi_len), 64'(15));
        chk("wd_timeout_set", 64'(o_timeout), 64'(1));
        rsp_en = 1'b1;
        rsp_lat = 0;
        push_spi(22'h61, 32'h0, 4'hF, 1'b0);
        push_rsp(1'b0, 32'h0000_0077);
        rdt_q.push_back(32'h0000_0077);
        ibus_req(22'h61);
        repeat (2) @(negedge clock);
        chk("wd_timeout_sticky", 64'(o_timeout), 64'(1));

        // Reset in the middle of a data grant
        rsp_en = 1'b0;
        push_spi(22'h70, 32'h7777_7777, 4'hF, 1'b1);
        i_dbus_adr = 22'h70; i_dbus_dat = 32'h7777_7777; i_dbus_sel = 4'hF; i_dbus_we = 1'b1;
        i_dbus_cyc = 1'b1;
        for (t = 0; t < 50; t++) begin
            @(negedge clock);
            if (o_spi_cyc) break;
        end
        chk("midrst_granted", 64'(o_spi_cyc), 64'(1));
        repeat (3) @(negedge clock);
        reset = 1'b1;
        i_dbus_cyc = 1'b0;
        #1;
        chk("midrst_cyc_async", 64'(o_spi_cyc), 64'(0));
        chk("midrst_init_done", 64'(o_init_done), 64'(0));
        chk("midrst_timeout", 64'(o_timeout), 64'(0));
        chk("midrst_dbus_ack", 64'(o_dbus_ack), 64'(0));
        repeat (2) @(negedge clock);
        rsp_en = 1'b1;
        rsp_lat = 2;
        push_spi(22'h0, 32'h0, 4'h0, 1'b1);
        rdt_q.push_back(32'h0);
        reset = 1'b0;
        wait_init_done();
        repeat (10) @(negedge clock);

        chk("spi_queue_drained", 64'(exp_spi.size()), 64'(0));
        chk("rsp_queue_drained", 64'(exp_rsp.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : global_guard
        #200000;
        $display("FAIL global_time_limit: run did not complete, compared %0d mismatched %0d", n_cmp, n_err);
        $fatal(1);
    end

endmodule

// File: doc/servant_spi_arbiter.md
SERVANT_SPI_ARBITER -- requirements
Module: servant_spi_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 24, meaning: byte-address width of the SPI memory space.
REQ-002 Parameter TIMEOUT, default 4095, meaning: max cycles a granted transfer may wait for downstream ack; 0 disables the watchdog.
REQ-003 Parameter INIT_WREN, default 1, meaning: 1 = issue one write-enable transfer after reset before serving requesters.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 i_ibus_adr  in  ADDRESS_WIDTH-2  instruction word address; i_ibus_cyc  in  1  instruction request (read-only).
REQ-007 o_ibus_rdt  out  32  instruction read data; o_ibus_ack  out  1  one-cycle completion pulse.
REQ-008 i_dbus_adr  in  ADDRESS_WIDTH-2; i_dbus_dat  in  32; i_dbus_sel  in  4; i_dbus_we  in  1; i_dbus_cyc  in  1: data request.
REQ-009 o_dbus_rdt  out  32; o_dbus_ack  out  1: data read data and one-cycle completion pulse.
REQ-010 o_spi_adr  out  ADDRESS_WIDTH-2; o_spi_dat  out  32; o_spi_sel  out  4; o_spi_we  out  1; o_spi_cyc  out  1: downstream request to SPI master interface.
REQ-011 i_spi_rdt  in  32; i_spi_ack  in  1: downstream read data and completion.
REQ-012 o_init_done  out  1  high once init sequence finished; o_timeout  out  1  sticky watchdog-expired flag.

Function
REQ-013 States SHALL be INIT, INIT_WAIT, IDLE, GRANT_I, GRANT_D, RELEASE.
REQ-014 INIT (INIT_WREN=1): drive o_spi_cyc=1, we=1, sel=4'h0, adr=0, dat=0; next INIT_WAIT.
REQ-015 INIT_WAIT: hold request until i_spi_ack; then drop cyc, set o_init_done, go RELEASE.
REQ-016 INIT_WREN=0: leave reset directly in IDLE with o_init_done=1 after first clock.
REQ-017 IDLE: sample cyc of both requesters; none -> stay IDLE with o_spi_cyc=0.
REQ-018 One requester -> grant it; both -> grant the one NOT granted last (round robin); last-grant pointer resets to ibus so dbus wins the first tie.
REQ-019 On grant, requester address/data/sel/we SHALL be registered into o_spi_* and o_spi_cyc asserted the next cycle; ibus grants force we=0, sel=4'hF, dat=0.
REQ-020 Requester inputs SHALL NOT affect o_spi_* while a grant is active (captured copy only).
REQ-021 GRANT_x: hold o_spi_cyc=1 until i_spi_ack; on ack register i_spi_rdt into o_x_rdt, pulse o_x_ack for exactly one cycle next cycle, drop o_spi_cyc same cycle, go RELEASE.
REQ-022 RELEASE: o_spi_cyc=0 for exactly one cycle, then IDLE; guarantees downstream sees cyc low between transfers.
REQ-023 A requester whose ack is high in a cycle SHALL NOT be granted on that cycle's sample.
REQ-024 i_spi_ack outside GRANT_x/INIT_WAIT SHALL be ignored.
REQ-025 Requester dropping cyc mid-grant: downstream transfer still completes; ack still pulsed once.
REQ-026 Watchdog: counter cleared at each grant/INIT, increments while waiting; on reaching TIMEOUT drop o_spi_cyc, pulse requester ack with rdt=32'hFFFFFFFF, set o_timeout, go RELEASE; in INIT_WAIT expiry sets o_timeout and o_init_done.
REQ-027 o_timeout SHALL clear only on reset.
REQ-028 ack latency: ack pulse exactly 1 cycle after i_spi_ack sampled high; min request-to-ack latency = 3 cycles + downstream latency.

Reset
REQ-029 Reset SHALL force state INIT (or IDLE per REQ-016), o_spi_cyc=0, o_spi_we=0, o_spi_sel=0, o_spi_adr=0, o_spi_dat=0, both acks 0, both rdt 0, o_init_done=0, o_timeout=0, watchdog=0, last-grant=ibus.
REQ-030 Reset mid-transfer SHALL drop o_spi_cyc immediately (asynchronous) and discard the pending transfer without ack.

Verification
REQ-031 After reset, INIT_WREN=1 -> one transfer we=1 sel=0; ack after 5 cycles -> o_init_done=1, no requester ack.
REQ-032 ibus and dbus both request in IDLE -> dbus granted first, ibus next; second tie -> ibus first.
REQ-033 dbus write adr=0x000010, dat=0xDEADBEEF, sel=4'h3 -> o_spi_* match exactly; ack -> o_dbus_ack one cycle, o_ibus_ack stays 0.
REQ-034 ibus read, i_spi_rdt=0x12345678 with ack -> o_ibus_rdt=0x12345678, o_ibus_ack single pulse, cyc low one cycle between back-to-back transfers.
REQ-035 TIMEOUT=15, downstream never acks -> cyc dropped after 15 cycles, ack with rdt 0xFFFFFFFF, o_timeout=1 until reset.
REQ-036 Assert reset during GRANT_D -> o_spi_cyc=0 immediately, no ack, INIT sequence restarts after release.
